// File: rtl/counter_readout_collector.sv
// Read-out stage for shared_counters: issues a read for one id, assembles the serial
// G-bit segment stream into a W-bit value and returns it on a valid/ready port.
module counter_readout_collector #(
  parameter int unsigned N       = 10,
  parameter int unsigned G       = 4,
  parameter int unsigned W       = 64,
  parameter int unsigned TIMEOUT = 15,
  localparam int unsigned IdW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [IdW-1:0] req_id,
  output logic [2:0]     cmd_out,
  output logic [IdW-1:0] id_out,
  input  logic [G-1:0]   rdata_in,
  input  logic           rvalid_in,
  input  logic           rlast_in,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [W-1:0]   rsp_data,
  output logic [7:0]     rsp_nseg,
  output logic           rsp_trunc,
  output logic           rsp_timeout
);

  localparam int unsigned NumSeg = W / G;
  localparam int unsigned WaitW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StCollect = 2'd1;
  localparam logic [1:0] StResp    = 2'd2;

  localparam logic [2:0] CmdRead = 3'b101;
  localparam logic [2:0] CmdIdle = 3'b000;

  logic [1:0]       state_q, state_d;
  logic [IdW-1:0]   id_q, id_d;
  logic [W-1:0]     data_q, data_d;
  logic [7:0]       seg_q, seg_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             trunc_q, trunc_d;
  logic             tmo_q, tmo_d;
  logic [2:0]       cmd_q, cmd_d;
  logic [IdW-1:0]   id_out_q, id_out_d;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    data_d  = data_q;
    seg_d   = seg_q;
    wait_d  = wait_q;
    trunc_d = trunc_q;
    tmo_d   = tmo_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = StCollect;
          id_d    = req_id;
          data_d  = '0;
          seg_d   = '0;
          wait_d  = '0;
          trunc_d = 1'b0;
          tmo_d   = 1'b0;
        end
      end
      StCollect: begin
        // A segment on the watchdog's final cycle still counts as data, not a timeout.
        if (rvalid_in) begin
          wait_d = '0;
          if (32'(seg_q) < NumSeg) begin
            for (int unsigned i = 0; i < NumSeg; i++) begin
              if (32'(seg_q) == i) data_d[i*G +: G] = rdata_in;
            end
          end else begin
            trunc_d = 1'b1;
          end
          if (seg_q != 8'hFF) seg_d = seg_q + 8'd1;
          if (rlast_in) state_d = StResp;
        end else if (wait_q == WaitW'(TIMEOUT - 1)) begin
          state_d = StResp;
          tmo_d   = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Command lines are registered off the next state so they change with the state itself.
  always_comb begin
    cmd_d    = (state_d == StCollect) ? CmdRead : CmdIdle;
    id_out_d = (state_d == StCollect) ? id_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      id_q     <= '0;
      data_q   <= '0;
      seg_q    <= '0;
      wait_q   <= '0;
      trunc_q  <= 1'b0;
      tmo_q    <= 1'b0;
      cmd_q    <= CmdIdle;
      id_out_q <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      data_q   <= data_d;
      seg_q    <= seg_d;
      wait_q   <= wait_d;
      trunc_q  <= trunc_d;
      tmo_q    <= tmo_d;
      cmd_q    <= cmd_d;
      id_out_q <= id_out_d;
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign rsp_valid   = (state_q == StResp);
  assign cmd_out     = cmd_q;
  assign id_out      = id_out_q;
  assign rsp_data    = data_q;
  assign rsp_nseg    = seg_q;
  assign rsp_trunc   = trunc_q;
  assign rsp_timeout = tmo_q;

endmodule

// File: tb/tb_counter_readout_collector.sv
// Directed bench for counter_readout_collector: a W=64 and a W=8 instance share stimulus;
// expected responses are queued as segments are driven and checked at each handshake.
module tb_counter_readout_collector;

  typedef struct packed {
    logic [63:0] d64;
    logic [7:0]  d8;
    logic [7:0]  nseg;
    logic        tr64;
    logic        tr8;
    logic        tmo;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, req_valid, rsp_ready, rvalid_in, rlast_in;
  logic [3:0]  req_id, rdata_in;
  logic        req_ready, rsp_valid, rsp_trunc, rsp_timeout;
  logic [2:0]  cmd_out;
  logic [3:0]  id_out;
  logic [63:0] rsp_data;
  logic [7:0]  rsp_nseg;
  logic        req_ready8, rsp_valid8, rsp_trunc8, rsp_timeout8;
  logic [2:0]  cmd_out8;
  logic [3:0]  id_out8;
  logic [7:0]  rsp_data8;
  logic [7:0]  rsp_nseg8;

  int checks = 0;
  int failures = 0;
  exp_t sbq[$];

  logic [63:0] m_d64;
  logic [7:0]  m_d8;
  int          m_nseg;
  logic        m_tr64, m_tr8;

  always #5 clk = ~clk;

  counter_readout_collector dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
    .cmd_out(cmd_out), .id_out(id_out), .rdata_in(rdata_in), .rvalid_in(rvalid_in),
    .rlast_in(rlast_in), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_nseg(rsp_nseg), .rsp_trunc(rsp_trunc), .rsp_timeout(rsp_timeout)
  );

  counter_readout_collector #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready8), .req_id(req_id),
    .cmd_out(cmd_out8), .id_out(id_out8), .rdata_in(rdata_in), .rvalid_in(rvalid_in),
    .rlast_in(rlast_in), .rsp_valid(rsp_valid8), .rsp_ready(rsp_ready), .rsp_data(rsp_data8),
    .rsp_nseg(rsp_nseg8), .rsp_trunc(rsp_trunc8), .rsp_timeout(rsp_timeout8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic [3:0] id);
    int n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("req_ready_wait", req_ready, 1'b1);
    m_d64 = '0; m_d8 = '0; m_nseg = 0; m_tr64 = 1'b0; m_tr8 = 1'b0;
    req_valid = 1'b1;
    req_id    = id;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic send_seg(input logic [3:0] d, input logic last);
    exp_t e;
    rvalid_in = 1'b1;
    rdata_in  = d;
    rlast_in  = last;
    if (m_nseg < 16) m_d64[m_nseg*4 +: 4] = d;
    else m_tr64 = 1'b1;
    if (m_nseg < 2) m_d8[m_nseg*4 +: 4] = d;
    else m_tr8 = 1'b1;
    if (m_nseg < 255) m_nseg++;
    if (last) begin
      e.d64 = m_d64; e.d8 = m_d8; e.nseg = 8'(m_nseg);
      e.tr64 = m_tr64; e.tr8 = m_tr8; e.tmo = 1'b0;
      sbq.push_back(e);
    end
    tick();
    rvalid_in = 1'b0;
    rlast_in  = 1'b0;
  endtask

  task automatic rsp_check(input string tag);
    exp_t e;
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, rsp_valid, 1'b1);
    chk({tag, "_valid8"}, rsp_valid8, 1'b1);
    chk({tag, "_sb_nonempty"}, 64'(sbq.size() > 0), 64'd1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({tag, "_data"}, rsp_data, e.d64);
      chk({tag, "_nseg"}, rsp_nseg, e.nseg);
      chk({tag, "_trunc"}, rsp_trunc, e.tr64);
      chk({tag, "_timeout"}, rsp_timeout, e.tmo);
      chk({tag, "_data8"}, rsp_data8, e.d8);
      chk({tag, "_nseg8"}, rsp_nseg8, e.nseg);
      chk({tag, "_trunc8"}, rsp_trunc8, e.tr8);
      chk({tag, "_timeout8"}, rsp_timeout8, e.tmo);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; rvalid_in = 1'b0; rlast_in = 1'b0;
    req_id = '0; rdata_in = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_cmd", cmd_out, 3'b000);
    chk("rst_id", id_out, 4'd0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    chk("rst_rsp_nseg", rsp_nseg, 8'd0);
    chk("rst_trunc", rsp_trunc, 1'b0);
    chk("rst_timeout", rsp_timeout, 1'b0);

    // Single segment
    do_req(4'd3);
    chk("s1_cmd_read", cmd_out, 3'b101);
    chk("s1_id", id_out, 4'd3);
    chk("s1_req_ready_low", req_ready, 1'b0);
    chk("s1_cmd8", cmd_out8, 3'b101);
    chk("s1_id8", id_out8, 4'd3);
    chk("s1_req_ready8", req_ready8, 1'b0);
    send_seg(4'hA, 1'b1);
    chk("s1_latency", rsp_valid, 1'b1);
    chk("s1_cmd_idle", cmd_out, 3'b000);
    chk("s1_id_idle", id_out, 4'd0);
    rsp_check("s1");
    chk("s1_back_idle", req_ready, 1'b1);

    // Three segments with 2-cycle gaps
    do_req(4'd7);
    send_seg(4'h3, 1'b0);
    tick(); chk("s3_gap_cmd", cmd_out, 3'b101);
    tick(); chk("s3_gap_valid", rsp_valid, 1'b0);
    send_seg(4'h2, 1'b0);
    tick(); tick(); chk("s3_gap2_cmd", cmd_out, 3'b101);
    send_seg(4'h1, 1'b1);
    chk("s3_cmd_idle", cmd_out, 3'b000);
    chk("s3_latency", rsp_valid, 1'b1);
    rsp_check("s3");

    // Backpressure, then back-to-back request; this second read also truncates W=8
    do_req(4'd9);
    send_seg(4'h5, 1'b0);
    send_seg(4'h9, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_req_ready", req_ready, 1'b0);
      chk("bp_data", rsp_data, 64'h95);
      chk("bp_nseg", rsp_nseg, 8'd2);
      chk("bp_cmd", cmd_out, 3'b000);
      tick();
    end
    rsp_check("bp");
    chk("bp_req_ready_after", req_ready, 1'b1);
    chk("bp_cmd_gap", cmd_out, 3'b000);
    do_req(4'd2);
    chk("bp_next_cmd", cmd_out, 3'b101);
    send_seg(4'h5, 1'b0);
    send_seg(4'h6, 1'b0);
    send_seg(4'h7, 1'b1);
    chk("tr_data8", rsp_data8, 8'h65);
    chk("tr_trunc8", rsp_trunc8, 1'b1);
    rsp_check("tr");

    // Timeout with no data
    do_req(4'd1);
    for (int i = 1; i < 15; i++) begin
      tick();
      chk("to_not_yet", rsp_valid, 1'b0);
    end
    e = '0; e.tmo = 1'b1;
    sbq.push_back(e);
    tick();
    chk("to_edge_valid", rsp_valid, 1'b1);
    chk("to_flag", rsp_timeout, 1'b1);
    rsp_check("to");

    // Segment with last on the watchdog's final cycle
    do_req(4'd4);
    for (int i = 1; i < 15; i++) tick();
    chk("tl_still_collect", cmd_out, 3'b101);
    send_seg(4'hC, 1'b1);
    chk("tl_valid", rsp_valid, 1'b1);
    rsp_check("tl");

    // Reset mid-collect
    do_req(4'd5);
    send_seg(4'h1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rc_cmd", cmd_out, 3'b000);
    chk("rc_id", id_out, 4'd0);
    chk("rc_valid", rsp_valid, 1'b0);
    chk("rc_data", rsp_data, 64'd0);
    chk("rc_nseg", rsp_nseg, 8'd0);
    chk("rc_req_ready", req_ready, 1'b1);
    tick(); tick();
    chk("rc_no_rsp", rsp_valid, 1'b0);
    do_req(4'd8);
    send_seg(4'hD, 1'b0);
    send_seg(4'hE, 1'b0);
    send_seg(4'hF, 1'b1);
    rsp_check("rc_new");
    chk("sb_drained", 64'(sbq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
